sap_control_unit: RTL

- Fetch/decode/execute sequencer for the 16-bit SAP datapath.
- Owns the PC, IR and latched ALU flags.
- Drives memory address/strobes, accumulator/B-register loads and the 4-bit ALU op. The ALU is combinational, with a = ACC and b = B.
- Instruction format: [15:12] opcode, [11:0] address.

---
 rtl/sap_control_unit_if.sv | 31 +++
 rtl/sap_control_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/sap_control_unit_if.sv
// rtl/sap_control_unit_if.sv - memory bus between the SAP sequencer and program/data memory
// SAP_MEM_WAIT_EN adds the mem_ready wait-state input.
interface sap_control_unit_if #(
  parameter int ADDR_W = 12
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [15:0]       mem_rdata;
`ifdef SAP_MEM_WAIT_EN
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr,
    input  mem_rdata, mem_ready
  );
  modport slave (
    input  mem_addr, mem_rd, mem_wr,
    output mem_rdata, mem_ready
  );
`else
  modport master (
    output mem_addr, mem_rd, mem_wr,
    input  mem_rdata
  );
  modport slave (
    input  mem_addr, mem_rd, mem_wr,
    output mem_rdata
  );
`endif
endinterface

// File: rtl/sap_control_unit.sv
// rtl/sap_control_unit.sv - SAP fetch/decode/execute sequencer owning PC, IR and ALU flags
// SAP_MEM_WAIT_EN: S_F0/S_M0 stall while mem_ready is low.
module sap_control_unit #(
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  sap_control_unit_if.master mem,
  input  logic [1:0]         alu_flag,
  output logic               acc_we,
  output logic               acc_src,
  output logic               b_we,
  output logic [3:0]         alu_op,
  output logic               out_we,
  output logic [ADDR_W-1:0]  pc,
  output logic [1:0]         flags,
  output logic               halted
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_INC = 4'h5;
  localparam logic [3:0] OP_DEC = 4'h6;
  localparam logic [3:0] OP_AND = 4'h7;
  localparam logic [3:0] OP_OR  = 4'h8;
  localparam logic [3:0] OP_XOR = 4'h9;
  localparam logic [3:0] OP_NOT = 4'hA;
  localparam logic [3:0] OP_JMP = 4'hB;
  localparam logic [3:0] OP_JZ  = 4'hC;
  localparam logic [3:0] OP_JO  = 4'hD;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_RST, S_F0, S_F1, S_DEC, S_M0, S_M1, S_EX, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [1:0]        flags_q, flags_d;

  logic [ADDR_W-1:0] mem_addr_c;
  logic              mem_rd_c;
  logic              mem_wr_c;
  logic              mem_ready;
  logic [3:0]        opc;
  logic [ADDR_W-1:0] ir_addr;

`ifdef SAP_MEM_WAIT_EN
  assign mem_ready = mem.mem_ready;
`else
  assign mem_ready = 1'b1;
`endif

  assign opc     = ir_q[15:12];
  assign ir_addr = ir_q[ADDR_W-1:0];

  // Opcodes 3..A double as ALU op codes; everything else defaults to ADD.
  always_comb begin
    alu_op = OP_ADD;
    if (opc >= OP_ADD && opc <= OP_NOT) alu_op = opc;
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    flags_d    = flags_q;
    mem_addr_c = '0;
    mem_rd_c   = 1'b0;
    mem_wr_c   = 1'b0;
    acc_we     = 1'b0;
    acc_src    = 1'b0;
    b_we       = 1'b0;
    out_we     = 1'b0;
    halted     = 1'b0;
    case (state_q)
      S_RST: state_d = S_F0;
      S_F0: begin
        mem_addr_c = pc_q;
        mem_rd_c   = 1'b1;
        if (mem_ready) state_d = S_F1;
      end
      S_F1: begin
        ir_d    = mem.mem_rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = S_DEC;
      end
      S_DEC: begin
        state_d = S_F0;
        case (opc)
          OP_NOP: ;
          OP_OUT: out_we = 1'b1;
          OP_JMP: pc_d = ir_addr;
          OP_JZ:  if (flags_q[0]) pc_d = ir_addr;
          OP_JO:  if (flags_q[1]) pc_d = ir_addr;
          OP_HLT: state_d = S_HALT;
          OP_INC, OP_DEC, OP_NOT: state_d = S_EX;
          default: state_d = S_M0;
        endcase
      end
      S_M0: begin
        mem_addr_c = ir_addr;
        if (opc == OP_STA) begin
          mem_wr_c = 1'b1;
          if (mem_ready) state_d = S_F0;
        end else begin
          mem_rd_c = 1'b1;
          if (mem_ready) state_d = S_M1;
        end
      end
      S_M1: begin
        mem_addr_c = ir_addr;
        if (opc == OP_LDA) begin
          acc_we  = 1'b1;
          acc_src = 1'b1;
          state_d = S_F0;
        end else begin
          b_we    = 1'b1;
          state_d = S_EX;
        end
      end
      S_EX: begin
        acc_we  = 1'b1;
        flags_d = alu_flag;
        state_d = S_F0;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  assign mem.mem_addr = mem_addr_c;
  assign mem.mem_rd   = mem_rd_c;
  assign mem.mem_wr   = mem_wr_c;
  assign pc           = pc_q;
  assign flags        = flags_q;

endmodule
